// File: rtl/bus_trace_card_pkg.sv
// Shared definitions for the bus trace card: bus widths, state encoding and
// the width of one stored trace entry.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 14
`endif

package bus_trace_card_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam int DEFAULT_DEPTH = 64;

  // One entry holds {addr, data, ctrl}; addr and data share the data width.
  function automatic int entry_width(input int dw, input int cw);
    return 2 * dw + cw;
  endfunction

endpackage

// File: rtl/bus_trace_card_trace_ram.sv
// Trace storage: one write port, one read port, synchronous read with a
// registered output that only updates on a read request.
module trace_ram
  import bus_trace_card_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = entry_width(`DATAWIDTH, `CTRLWIDTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array write; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_trace_card.sv
// Bus trace card: passively records {addr, data, ctrl} into a circular
// buffer while armed, stops a programmable number of samples after a
// masked ctrl trigger, then offers the frozen trace for indexed readout.
module bus_trace_card
  import bus_trace_card_pkg::*;
#(
  parameter int DATAWIDTH = `DATAWIDTH,
  parameter int CTRLWIDTH = `CTRLWIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = entry_width(DATAWIDTH, CTRLWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:0] data,
  input  logic [DATAWIDTH-1:0] addr,
  input  logic [CTRLWIDTH-1:0] ctrl,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [CTRLWIDTH-1:0] trig_mask,
  input  logic [CTRLWIDTH-1:0] trig_value,
  input  logic [AW-1:0]        post_len,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_idx,
  output logic [EW-1:0]        rd_data,
  output logic                 rd_valid,
  output logic [1:0]           state,
  output logic [AW:0]          count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_t  st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] post_cnt;
  logic          trig_hit;
  logic          we;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;

  assign state    = st;
  assign trig_hit = ((ctrl ^ trig_value) & trig_mask) == '0;
  // abort wins over the write so the aborted cycle leaves the buffer alone.
  assign we       = ((st == ST_ARMED) || (st == ST_POST)) && !abort;
  assign rd_ok    = rd_en && (st == ST_DONE) && ({1'b0, rd_idx} < count);
  // Oldest entry sits count slots behind wr_ptr; when full count[AW-1:0] is 0.
  assign rd_addr  = wr_ptr - count[AW-1:0] + rd_idx;

  // Capture control: state, write pointer, fill count and post-trigger counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else if (abort) begin
      st       <= ST_IDLE;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL) count <= count + 1'b1;
      end
      case (st)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            st     <= ST_ARMED;
            count  <= '0;
            wr_ptr <= '0;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            if (post_len == '0) begin
              st <= ST_DONE;
            end else begin
              st       <= ST_POST;
              post_cnt <= post_len;
            end
          end
        end
        ST_POST: begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == AW'(1)) st <= ST_DONE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // rd_valid tracks whether the RAM output register was refreshed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_ok;
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({addr, data, ctrl}),
    .re    (rd_ok),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
